// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multi-cycle controller: opcodes, functs,
// FSM state encoding, PC source select and the decoded instruction class.
// Optional feature macro: MIPS_CTRL_MULDIV_EN (mult/multu/div/divu sequencing).
package mips_ctrl_pkg;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instruction[5:0]); these double as ALU function codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // FSM state encoding, also exported on the debug state port
  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_MULDIV = 3'd6
  } state_e;

  // pc_src select values
  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_RS     = 2'd2;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd3;

  // One-hot instruction class; all-zero means undecodable
  typedef struct packed {
    logic rtype;
    logic jr;
    logic alu_i;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic nop;
    logic muldiv;
  } instr_class_t;

  // Ordinary single-cycle ALU functs executed through EXEC -> WB
  function automatic logic is_alu_funct(input logic [5:0] fn);
    case (fn)
      FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
      FN_MFHI, FN_MFLO,
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: is_alu_funct = 1'b1;
      default:                                        is_alu_funct = 1'b0;
    endcase
  endfunction

  // Multi-cycle HI/LO producers
  function automatic logic is_muldiv_funct(input logic [5:0] fn);
    is_muldiv_funct = (fn == FN_MULT) || (fn == FN_MULTU) ||
                      (fn == FN_DIV)  || (fn == FN_DIVU);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_class.sv
// Combinational instruction classifier: IR -> one-hot class, mapped ALU
// function code and an illegal flag.
// Optional feature macro: MIPS_CTRL_MULDIV_EN (mult/div functs become legal).
module mips_instr_class
  import mips_ctrl_pkg::*;
(
  input  logic [31:0]  ir,
  output instr_class_t cls,
  output logic [5:0]   alu_op,
  output logic         illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];

  // Classify the instruction and pick the ALU function it needs
  always_comb begin
    cls     = '0;
    alu_op  = 6'h00;
    illegal = 1'b0;
    if (ir == 32'h0000_0000) begin
      // The all-zero word is sll $0,$0,0; treat it as a cheap NOP
      cls.nop = 1'b1;
    end else begin
      case (opcode)
        OP_RTYPE: begin
          if (funct == FN_JR) begin
            cls.jr = 1'b1;
          end else if (is_alu_funct(funct)) begin
            cls.rtype = 1'b1;
            alu_op    = funct;
          end
`ifdef MIPS_CTRL_MULDIV_EN
          else if (is_muldiv_funct(funct)) begin
            cls.muldiv = 1'b1;
            alu_op     = funct;
          end
`endif
          else begin
            illegal = 1'b1;
          end
        end
        OP_J:    cls.j = 1'b1;
        OP_BEQ: begin
          cls.beq = 1'b1;
          alu_op  = FN_SUB;
        end
        OP_ADDI: begin
          cls.alu_i = 1'b1;
          alu_op    = FN_ADD;
        end
        OP_ANDI: begin
          cls.alu_i = 1'b1;
          alu_op    = FN_AND;
        end
        OP_ORI: begin
          cls.alu_i = 1'b1;
          alu_op    = FN_OR;
        end
        OP_LW: begin
          cls.lw = 1'b1;
          alu_op = FN_ADD;
        end
        OP_SW: begin
          cls.sw = 1'b1;
          alu_op = FN_ADD;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle sequencing controller for the MIPS datapath. Steps the shared
// datapath through FETCH/DECODE/EXEC/MEM/WB and owns every datapath enable.
// Optional feature macro: MIPS_CTRL_MULDIV_EN adds the MULDIV state and the
// hilo_write output.
//
// Memory handshake: a request (imem_req / dmem_req) is held high until the
// matching ack is seen; the ack may arrive in the very cycle the request rises
// and completes the transfer in that cycle. Acks arriving while no request is
// outstanding are ignored, and a reset drops any outstanding request.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        alu_zero,
  output logic        imem_req,
  output logic        ir_load,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [5:0]  ALUop,
  output logic        use_imm,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        jump_register,
  output logic        illegal,
`ifdef MIPS_CTRL_MULDIV_EN
  output logic        hilo_write,
`endif
  output logic [2:0]  state
);

  // Counter reload value: counts down to zero, so N cycles start at N-1
  localparam logic [5:0] MULDIV_LAST = 6'(MULDIV_CYCLES - 1);

  state_e       state_q, state_d;
  logic [31:0]  ir_q, ir_d;
  logic [5:0]   cnt_q, cnt_d;

  instr_class_t cls;
  logic [5:0]   dec_alu_op;
  logic         dec_illegal;

  mips_instr_class u_class (
    .ir      (ir_q),
    .cls     (cls),
    .alu_op  (dec_alu_op),
    .illegal (dec_illegal)
  );

  assign state = state_q;

  // State, internal IR copy and MULDIV countdown registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      ir_q    <= 32'h0000_0000;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic, IR capture and MULDIV countdown
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = instruction;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cls.j || cls.nop || dec_illegal) begin
          state_d = S_FETCH;
        end else if (cls.muldiv) begin
          state_d = S_MULDIV;
          cnt_d   = MULDIV_LAST;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls.lw || cls.sw) begin
          state_d = S_MEM;
        end else if (cls.rtype || cls.alu_i) begin
          state_d = S_WB;
        end else begin
          // JR and beq complete in EXEC
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_d = cls.lw ? S_WB : S_FETCH;
        end
      end
      S_WB: state_d = S_FETCH;
      S_MULDIV: begin
        if (cnt_q == 6'd0) begin
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: state_d = S_RST;
    endcase
  end

  // Datapath enables decoded from the current state and the IR class
  always_comb begin
    imem_req      = 1'b0;
    ir_load       = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PC_SRC_SEQ;
    ALUop         = 6'h00;
    use_imm       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    jump_register = 1'b0;
    illegal       = 1'b0;
`ifdef MIPS_CTRL_MULDIV_EN
    hilo_write    = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_SRC_SEQ;
        end
      end
      S_DECODE: begin
        illegal = dec_illegal;
        if (cls.j) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_JUMP;
        end
      end
      S_EXEC: begin
        ALUop   = dec_alu_op;
        use_imm = cls.alu_i || cls.lw || cls.sw;
        if (cls.jr) begin
          jump_register = 1'b1;
          pc_write      = 1'b1;
          pc_src        = PC_SRC_RS;
        end
        if (cls.beq) begin
          pc_write = alu_zero;
          pc_src   = PC_SRC_BRANCH;
        end
      end
      S_MEM: begin
        ALUop    = dec_alu_op;
        dmem_req = 1'b1;
        dmem_we  = cls.sw;
      end
      S_WB: begin
        ALUop      = dec_alu_op;
        reg_write  = 1'b1;
        mem_to_reg = cls.lw;
      end
      S_MULDIV: begin
        ALUop = dec_alu_op;
`ifdef MIPS_CTRL_MULDIV_EN
        hilo_write = (cnt_q == 6'd0);
`endif
      end
      default: ;
    endcase
  end

endmodule
